// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller: FSM encoding and scoreboard slot record.
package pipe_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dest: '0};

    // Register 0 is hard-wired zero, so a write to it never becomes a tracked destination.
    function automatic slot_t mk_slot(input logic wr, input logic [REG_W-1:0] dst);
        slot_t s;
        s.valid = wr && (dst != '0);
        s.dest  = dst;
        return s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker (EX, MEM, WB) and read-after-write match compare.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  slot_t            load_slot,
    input  logic             rd_en,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    output logic             match
);

    slot_t slots [DEPTH];

    // Advance the slots with the EX stage; hold while the back end is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= SLOT_EMPTY;
        end else if (shift_en) begin
            slots[0] <= load_slot;
            for (int i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
        end
    end

    // Any valid non-zero destination equal to either source register is a hazard.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slots[i].valid && (slots[i].dest != '0) &&
                ((slots[i].dest == src1) || (slots[i].dest == src2)))
                hit = 1'b1;
        end
        match = rd_en && hit;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables around decode, bubbles for RAW hazards,
// jump flush, memory freeze, halt/resume, and a saturating stall counter.
//
//   state | meaning
//   BOOT  | one idle cycle after reset, all enables off
//   RUN   | normal issue
//   FLUSH | one cycle retiring the wrong-path slot as a bubble
//   HALT  | no issue, back end drains; RESUME returns to RUN
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int NREG  = 16,
    parameter int DEPTH = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    WILLWRITE,
    input  logic [$clog2(NREG)-1:0] STARTREG,
    input  logic                    READREG,
    input  logic [$clog2(NREG)-1:0] READREG1,
    input  logic [$clog2(NREG)-1:0] READREG2,
    input  logic                    JUMP_TAKEN,
    input  logic                    MEM_BUSY,
    input  logic                    HALT_REQ,
    input  logic                    RESUME,
    output logic                    STAGE1EN,
    output logic                    STAGE2IN,
    output logic                    STAGE2OUT,
    output logic                    STAGE3EN,
    output logic                    STAGE4EN,
    output logic                    STALL,
    output logic [1:0]              STATE,
    output logic [15:0]             STALLCNT
);

    state_t state, state_nxt;
    logic   sb_match;
    logic   haz;
    slot_t  load_slot;

    assign load_slot = STAGE2OUT ? mk_slot(WILLWRITE, STARTREG) : SLOT_EMPTY;

    hazard_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk       (CLK),
        .rst_n     (RST_N),
        .shift_en  (STAGE3EN),
        .load_slot (load_slot),
        .rd_en     (READREG),
        .src1      (READREG1),
        .src2      (READREG2),
        .match     (sb_match)
    );

    assign haz   = (state == RUN) && sb_match;
    assign STATE = state;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= BOOT;
        else        state <= state_nxt;
    end

    // Next state and enable decode, highest priority first. A frozen back end
    // holds the state so a jump held by EX is taken once memory is ready.
    always_comb begin
        state_nxt = state;
        STAGE1EN  = 1'b0;
        STAGE2IN  = 1'b0;
        STAGE2OUT = 1'b0;
        STAGE3EN  = 1'b0;
        STAGE4EN  = 1'b0;
        STALL     = 1'b0;
        if (state == BOOT) begin
            state_nxt = RUN;
        end else if (MEM_BUSY) begin
            STAGE2IN = 1'b1;
            STALL    = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    STAGE3EN = 1'b1;
                    STAGE4EN = 1'b1;
                    if (JUMP_TAKEN) begin
                        STAGE1EN  = 1'b1;
                        state_nxt = FLUSH;
                    end else if (haz) begin
                        STAGE2IN = 1'b1;
                        STALL    = 1'b1;
                    end else begin
                        STAGE1EN  = 1'b1;
                        STAGE2IN  = 1'b1;
                        STAGE2OUT = 1'b1;
                        if (HALT_REQ) state_nxt = HALT;
                    end
                end
                FLUSH: begin
                    STAGE1EN  = 1'b1;
                    STAGE2IN  = 1'b1;
                    STAGE3EN  = 1'b1;
                    STAGE4EN  = 1'b1;
                    state_nxt = RUN;
                end
                HALT: begin
                    STAGE3EN = 1'b1;
                    STAGE4EN = 1'b1;
                    if (RESUME) state_nxt = RUN;
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                           STALLCNT <= '0;
        else if (STALL && STALLCNT != 16'hFFFF) STALLCNT <= STALLCNT + 16'd1;
    end

endmodule
